// File: rtl/reset_sequencer.sv
// Staged reset release controller: holds all subsystem resets, then releases them one at a
// time, waiting for each stage's ready; faults on a stuck stage and re-sequences on restart.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  DEVICE_INIT_DONE,
    input  logic                  PLL_LOCK,
    input  logic                  SOFT_RST_REQ,
    input  logic [NUM_STAGES-1:0] STAGE_READY,
    output logic [NUM_STAGES-1:0] STAGE_RESETN,
    output logic                  SEQ_DONE,
    output logic                  SEQ_FAULT,
    output logic [2:0]            FAULT_STAGE,
    output logic [2:0]            STATE
);

    localparam int unsigned CntMaxHg = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntMax   = (CntMaxHg > TIMEOUT_CYCLES) ? CntMaxHg : TIMEOUT_CYCLES;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] HoldLast    = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast     = CntW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast =
        CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);
    localparam logic [CntW-1:0] CntSat      = {CntW{1'b1}};
    localparam logic [2:0]      LastStage   = 3'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StHold    = 3'd1,
        StWaitRdy = 3'd2,
        StGap     = 3'd3,
        StRun     = 3'd4,
        StFault   = 3'd5
    } state_e;

    logic                  lock_meta_q;
    logic                  lock_s_q;
    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2:0]            k_q, k_d;
    logic [NUM_STAGES-1:0] stage_resetn_q, stage_resetn_d;
    logic                  seq_done_q, seq_done_d;
    logic                  seq_fault_q, seq_fault_d;
    logic [2:0]            fault_stage_q, fault_stage_d;

    logic                  stage_ready_k;
    logic                  restart;
    logic [CntW-1:0]       cnt_inc;

    // Ready of the stage currently being waited on.
    always_comb begin
        stage_ready_k = 1'b0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if (k_q == 3'(i)) begin
                stage_ready_k = STAGE_READY[i];
            end
        end
    end

    always_comb begin
        cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + CntOne;
        restart = (state_q != StIdle) && (!lock_s_q || SOFT_RST_REQ);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        k_d           = k_q;
        fault_stage_d = fault_stage_q;

        if (restart) begin
            state_d = StIdle;
            cnt_d   = '0;
            k_d     = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (DEVICE_INIT_DONE && lock_s_q) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end
                end
                StHold: begin
                    if (cnt_q == HoldLast) begin
                        state_d = StWaitRdy;
                        cnt_d   = '0;
                        k_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StWaitRdy: begin
                    // Ready is checked before the timeout so it wins on the final cycle.
                    if (stage_ready_k) begin
                        cnt_d = '0;
                        if (k_q == LastStage) begin
                            state_d = StRun;
                        end else if (GAP_CYCLES == 0) begin
                            state_d = StWaitRdy;
                            k_d     = k_q + 3'd1;
                        end else begin
                            state_d = StGap;
                        end
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast)) begin
                        state_d       = StFault;
                        fault_stage_d = k_q;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        state_d = StWaitRdy;
                        k_d     = k_q + 3'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StRun, StFault: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    k_d     = '0;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so they change on the same edge as the FSM.
    always_comb begin
        seq_done_d  = (state_d == StRun);
        seq_fault_d = (state_d == StFault);
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            stage_resetn_d[i] = ((state_d == StWaitRdy) || (state_d == StGap) ||
                                 (state_d == StRun)) && (k_d >= 3'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            lock_meta_q    <= 1'b0;
            lock_s_q       <= 1'b0;
            state_q        <= StIdle;
            cnt_q          <= '0;
            k_q            <= '0;
            stage_resetn_q <= '0;
            seq_done_q     <= 1'b0;
            seq_fault_q    <= 1'b0;
            fault_stage_q  <= '0;
        end else begin
            lock_meta_q    <= PLL_LOCK;
            lock_s_q       <= lock_meta_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            k_q            <= k_d;
            stage_resetn_q <= stage_resetn_d;
            seq_done_q     <= seq_done_d;
            seq_fault_q    <= seq_fault_d;
            fault_stage_q  <= fault_stage_d;
        end
    end

    assign STAGE_RESETN = stage_resetn_q;
    assign SEQ_DONE     = seq_done_q;
    assign SEQ_FAULT    = seq_fault_q;
    assign FAULT_STAGE  = fault_stage_q;
    assign STATE        = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (GAP=2 and GAP=0) driven together, compared each
// cycle against a timeline model built from release/ready/timeout arithmetic.
module tb_reset_sequencer;

    localparam int NS   = 4;
    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int TO   = 10;
    localparam int KSoft = 0;
    localparam int KLock = 1;
    localparam int KRst  = 2;
    localparam int Never = 1 << 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn, init_done, pll_lock, soft_req;
    logic [NS-1:0] rdy_g2, rdy_g0, rn_g2, rn_g0;
    logic          done_g2, done_g0, flt_g2, flt_g0;
    logic [2:0]    fst_g2, fst_g0, st_g2, st_g0;

    int checks   = 0;
    int failures = 0;
    int dly[4];
    int fs_exp[2];

    reset_sequencer #(
        .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) u_dut_g2 (
        .CLK(clk), .RESETN(resetn), .DEVICE_INIT_DONE(init_done), .PLL_LOCK(pll_lock),
        .SOFT_RST_REQ(soft_req), .STAGE_READY(rdy_g2), .STAGE_RESETN(rn_g2),
        .SEQ_DONE(done_g2), .SEQ_FAULT(flt_g2), .FAULT_STAGE(fst_g2), .STATE(st_g2)
    );

    reset_sequencer #(
        .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)
    ) u_dut_g0 (
        .CLK(clk), .RESETN(resetn), .DEVICE_INIT_DONE(init_done), .PLL_LOCK(pll_lock),
        .SOFT_RST_REQ(soft_req), .STAGE_READY(rdy_g0), .STAGE_RESETN(rn_g0),
        .SEQ_DONE(done_g0), .SEQ_FAULT(flt_g0), .FAULT_STAGE(fst_g0), .STATE(st_g0)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input int c, input logic [3:0] obs,
                         input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Cycle c=0 is the first IDLE cycle with preconditions; rel[k] is the cycle stage k is
    // released, cf the cycle the fault shows, cd the cycle SEQ_DONE shows.
    function automatic void timeline(input int gap, output int rel[4], output int f,
                                     output int cf, output int cd);
        f  = -1;
        cf = Never;
        cd = Never;
        for (int k = 0; k < NS; k++) rel[k] = Never;
        rel[0] = 1 + HOLD;
        for (int k = 0; k < NS; k++) begin
            if (f < 0 && rel[k] != Never) begin
                if (dly[k] >= TO) begin
                    f  = k;
                    cf = rel[k] + TO;
                end else if (k < NS - 1) begin
                    rel[k+1] = rel[k] + dly[k] + 1 + gap;
                end else begin
                    cd = rel[k] + dly[k] + 1;
                end
            end
        end
    endfunction

    function automatic void model(input int gap, input int c, input int kind, input int ce,
                                  output logic [2:0] st, output logic [3:0] rn,
                                  output logic dn, output logic ft, output int fupd);
        int rel[4];
        int f, cf, cd;
        timeline(gap, rel, f, cf, cd);
        st = 3'd0; rn = 4'h0; dn = 1'b0; ft = 1'b0; fupd = -1;
        if (f >= 0 && c >= cf && cf < ce) fupd = f;
        if (c >= ce) begin
            if (kind == KRst) fupd = -2;
        end else if (c == 0) begin
            st = 3'd0;
        end else if (c < rel[0]) begin
            st = 3'd1;
        end else if (f >= 0 && c >= cf) begin
            st = 3'd5;
            ft = 1'b1;
        end else if (c >= cd) begin
            st = 3'd4;
            rn = 4'hf;
            dn = 1'b1;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (rel[k] <= c) begin
                    rn[k] = 1'b1;
                    st = (c <= rel[k] + dly[k]) ? 3'd2 : 3'd3;
                end
            end
        end
    endfunction

    // Ready is 0 while a stage is waited on, rises on its scheduled cycle, random otherwise.
    function automatic logic [3:0] ready_for(input int gap, input int c);
        int rel[4];
        int f, cf, cd;
        logic [3:0] r;
        timeline(gap, rel, f, cf, cd);
        for (int k = 0; k < NS; k++) begin
            if (c < rel[k])                r[k] = 1'($urandom_range(0, 1));
            else if (c < rel[k] + dly[k])  r[k] = 1'b0;
            else if (c == rel[k] + dly[k]) r[k] = 1'b1;
            else                           r[k] = 1'($urandom_range(0, 1));
        end
        return r;
    endfunction

    task automatic check_dut(input int idx, input int c, input int kind, input int ce);
        logic [2:0] st;
        logic [3:0] rn;
        logic dn, ft;
        int fu;
        model((idx == 0) ? GAP : 0, c, kind, ce, st, rn, dn, ft, fu);
        if (fu >= 0) fs_exp[idx] = fu;
        else if (fu == -2) fs_exp[idx] = 0;
        if (idx == 0) begin
            check("g2_state", c, {1'b0, st_g2}, {1'b0, st});
            check("g2_resetn", c, rn_g2, rn);
            check("g2_done", c, {3'b0, done_g2}, {3'b0, dn});
            check("g2_fault", c, {3'b0, flt_g2}, {3'b0, ft});
            check("g2_fstage", c, {1'b0, fst_g2}, 4'(fs_exp[0]));
        end else begin
            check("g0_state", c, {1'b0, st_g0}, {1'b0, st});
            check("g0_resetn", c, rn_g0, rn);
            check("g0_done", c, {3'b0, done_g0}, {3'b0, dn});
            check("g0_fault", c, {3'b0, flt_g0}, {3'b0, ft});
            check("g0_fstage", c, {1'b0, fst_g0}, 4'(fs_exp[1]));
        end
    endtask

    // One sequence from c=0, ended by a restart event of the given kind at cycle ca.
    task automatic run_seq(input int kind, input int ca);
        int ce, clast;
        ce    = ca + ((kind == KLock) ? 3 : 1);
        clast = ca + ((kind == KLock) ? 5 : (kind == KRst) ? 3 : 1);
        for (int c = 0; c <= clast; c++) begin
            if (c > 0) step();
            check_dut(0, c, kind, ce);
            check_dut(1, c, kind, ce);
            resetn    = !(kind == KRst && c == ca);
            pll_lock  = !(kind == KLock && c >= ca && c < ca + 3);
            soft_req  = (kind == KSoft && c == ca) ||
                        ((c == 0 || c >= ce) && $urandom_range(0, 1) == 1);
            init_done = (c >= 1 && c < ce) ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy_g2    = ready_for(GAP, c);
            rdy_g0    = ready_for(0, c);
        end
    endtask

    initial begin
        int rel[4];
        int f, cf, cd, nat, kind, ca;
        resetn = 1'b0; init_done = 1'b1; pll_lock = 1'b1; soft_req = 1'b0;
        rdy_g2 = 4'hf; rdy_g0 = 4'hf;
        fs_exp[0] = 0; fs_exp[1] = 0;
        repeat (3) step();
        check_dut(0, 0, KSoft, Never);
        check_dut(1, 0, KSoft, Never);

        resetn = 1'b1; init_done = 1'b0;
        repeat (4) step();
        check("idle_noinit", 0, {1'b0, st_g2}, 4'h0);
        soft_req = 1'b1;
        step();
        soft_req = 1'b0;
        check("idle_soft", 0, {1'b0, st_g2}, 4'h0);
        check("idle_soft_rn", 0, rn_g2, 4'h0);
        init_done = 1'b1;

        dly = '{0, 0, 0, 0};  run_seq(KSoft, 18);
        dly = '{0, 0, 6, 0};  run_seq(KSoft, 22);
        dly = '{0, 15, 0, 0}; run_seq(KSoft, 20);
        dly = '{0, 0, 0, 0};  run_seq(KRst, 9);
        dly = '{0, 0, 0, 0};  run_seq(KLock, 17);
        dly = '{0, 0, 0, 4};  run_seq(KLock, 16);

        repeat (25) begin
            for (int k = 0; k < NS; k++) dly[k] = int'($urandom_range(0, 12));
            timeline(GAP, rel, f, cf, cd);
            nat  = (f >= 0) ? cf : cd;
            kind = int'($urandom_range(0, 2));
            ca   = int'($urandom_range(2, nat + 3));
            run_seq(kind, ca);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
